temp_frame_tx: RTL

Framing stage between the averaging block and the basic UART transmitter in the ring-oscillator temperature sensor. It takes each 16-bit averaged count, wraps it in a fixed byte frame (sync, sequence, MSB, LSB, checksum) and drives the UART tx_start/tx_data/tx_busy handshake one byte at a time. A one-entry pending buffer absorbs samples that arrive mid-frame, and a saturating counter records samples that are dropped.

---
 rtl/temp_frame_tx.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/temp_frame_tx.sv
// Framing stage between the sample averager and the UART transmitter: wraps each 16-bit
// count as SYNC, [SEQ], MSB, LSB, CHK and paces the bytes over the tx_start/tx_busy handshake.
module temp_frame_tx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned SEQ_EN    = 1,
    parameter int unsigned BUSY_TO   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample_in,
    input  logic        sample_valid,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        frame_busy,
    output logic        frame_done,
    output logic [7:0]  seq,
    output logic [7:0]  drop_cnt
);
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned LAST_IDX = (SEQ_EN != 0) ? 4 : 3;
    localparam int unsigned TO_W     = (BUSY_TO > 2) ? $clog2(BUSY_TO) : 1;
    localparam int unsigned TO_LAST  = (BUSY_TO > 0) ? BUSY_TO - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [15:0]        frame_smp_q, frame_smp_d;
    logic [7:0]         frame_seq_q, frame_seq_d;
    logic [15:0]        pend_data_q, pend_data_d;
    logic               pend_full_q, pend_full_d;
    logic [7:0]         drop_cnt_q, drop_cnt_d;
    logic [7:0]         seq_q, seq_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               frame_busy_q, frame_busy_d;
    logic               frame_done_q, frame_done_d;

    // Byte at a given frame position; without the sequence byte, later positions shift down by one.
    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx,
                                              input logic [15:0]      smp,
                                              input logic [7:0]       sq);
        logic [IDX_W-1:0] slot;
        logic [7:0]       seq_term;
        logic [7:0]       chk;
        seq_term = (SEQ_EN != 0) ? sq : 8'h00;
        chk      = SYNC_BYTE ^ seq_term ^ smp[15:8] ^ smp[7:0];
        slot     = ((SEQ_EN == 0) && (idx != '0)) ? idx + IDX_W'(1) : idx;
        case (slot)
            IDX_W'(0): frame_byte = SYNC_BYTE;
            IDX_W'(1): frame_byte = sq;
            IDX_W'(2): frame_byte = smp[15:8];
            IDX_W'(3): frame_byte = smp[7:0];
            default:   frame_byte = chk;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            to_cnt_q     <= '0;
            frame_smp_q  <= '0;
            frame_seq_q  <= '0;
            pend_data_q  <= '0;
            pend_full_q  <= 1'b0;
            drop_cnt_q   <= '0;
            seq_q        <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            frame_busy_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            to_cnt_q     <= to_cnt_d;
            frame_smp_q  <= frame_smp_d;
            frame_seq_q  <= frame_seq_d;
            pend_data_q  <= pend_data_d;
            pend_full_q  <= pend_full_d;
            drop_cnt_q   <= drop_cnt_d;
            seq_q        <= seq_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            frame_busy_q <= frame_busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        to_cnt_d     = to_cnt_q;
        frame_smp_d  = frame_smp_q;
        frame_seq_d  = frame_seq_q;
        pend_data_d  = pend_data_q;
        pend_full_d  = pend_full_q;
        drop_cnt_d   = drop_cnt_q;
        seq_d        = seq_q;
        tx_data_d    = tx_data_q;

        // A sample arriving while LOAD empties the buffer refills it without counting a drop.
        if (sample_valid) begin
            pend_data_d = sample_in;
            pend_full_d = 1'b1;
            if (pend_full_q && (state_q != ST_LOAD) && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (state_q == ST_LOAD) begin
            pend_full_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (pend_full_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                frame_smp_d = pend_data_q;
                frame_seq_d = seq_q;
                idx_d       = '0;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                to_cnt_d = '0;
                state_d  = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                // A UART that never raises busy is assumed to have taken the byte after BUSY_TO cycles.
                if (tx_busy || (to_cnt_q == TO_W'(TO_LAST))) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = ST_DONE;
                        seq_d   = seq_q + 8'd1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        tx_start_d   = (state_d == ST_SEND);
        frame_done_d = (state_d == ST_DONE);
        frame_busy_d = (state_d == ST_LOAD) || (state_d == ST_SEND) ||
                       (state_d == ST_WAIT_BUSY) || (state_d == ST_WAIT_DONE);
        if (state_d == ST_SEND) begin
            tx_data_d = frame_byte(idx_d, frame_smp_d, frame_seq_d);
        end
    end

    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign frame_busy = frame_busy_q;
    assign frame_done = frame_done_q;
    assign seq        = seq_q;
    assign drop_cnt   = drop_cnt_q;

endmodule
